// File: rtl/tc_arb_pkg.sv
// Shared types, sizes and the rotating-priority winner search for tc_rr_arbiter4.
package tc_arb_pkg;

    localparam int unsigned IDX_W = 2;
    localparam int unsigned N_REQ = 4;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    // Scan ptr+1, ptr+2, ptr+3, ptr (mod 4); with exclude set, ptr itself is skipped.
    function automatic logic [IDX_W-1:0] next_winner(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr,
        input logic             exclude
    );
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] win;
        logic             found;
        win   = ptr;
        found = 1'b0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            idx = ptr + IDX_W'(k);
            if (!found && req[idx] && !(exclude && (idx == ptr))) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/tc_arb_onehot_dec.sv
// 2-bit index to 4-bit one-hot decoder.
module tc_arb_onehot_dec
    import tc_arb_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    output logic [N_REQ-1:0] o_onehot
);

    always_comb begin
        o_onehot        = '0;
        o_onehot[i_idx] = 1'b1;
    end

endmodule

// File: rtl/tc_rr_arbiter4.sv
// Four-way round-robin arbiter with registered grant and optional hold-time limit.
// Define TC_RR_ARBITER4_LOCK_EN to add i_lock, which suppresses the hold-time release.
module tc_rr_arbiter4
    import tc_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
`ifdef TC_RR_ARBITER4_LOCK_EN
    input  logic             i_lock,
`endif
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_gnt_valid,
    output logic [CNT_W-1:0] o_busy_cycles
);

    localparam bit               HoldEn   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

    arb_state_e       r_state, w_state_d;
    logic [IDX_W-1:0] r_ptr, w_ptr_d;
    logic [N_REQ-1:0] r_gnt, w_gnt_d;
    logic [IDX_W-1:0] r_gnt_idx, w_idx_d;
    logic             r_gnt_valid, w_valid_d;
    logic [CNT_W-1:0] r_busy, w_busy_d;

    logic [IDX_W-1:0] w_win_idx;
    logic [N_REQ-1:0] w_win_oh;
    logic [N_REQ-1:0] w_others;
    logic             w_lock;
    logic             w_timeout;
    logic             w_release;

`ifdef TC_RR_ARBITER4_LOCK_EN
    assign w_lock = i_lock;
`else
    assign w_lock = 1'b0;
`endif

    // In GRANT the search starts after the owner and skips it; in IDLE it starts after ptr.
    assign w_win_idx = next_winner(i_req, (r_state == StGrant) ? r_gnt_idx : r_ptr,
                                   r_state == StGrant);

    tc_arb_onehot_dec u_dec (
        .i_idx    (w_win_idx),
        .o_onehot (w_win_oh)
    );

    // r_gnt is the owner's one-hot while in GRANT.
    assign w_others  = i_req & ~r_gnt;
    assign w_timeout = HoldEn && (r_busy == HoldLast) && (|w_others) && !w_lock;
    assign w_release = !i_req[r_gnt_idx] || w_timeout;

    always_comb begin
        w_state_d = r_state;
        w_ptr_d   = r_ptr;
        w_gnt_d   = r_gnt;
        w_idx_d   = r_gnt_idx;
        w_valid_d = r_gnt_valid;
        w_busy_d  = r_busy;
        unique case (r_state)
            StIdle: begin
                if (|i_req) begin
                    w_state_d = StGrant;
                    w_gnt_d   = w_win_oh;
                    w_idx_d   = w_win_idx;
                    w_valid_d = 1'b1;
                    w_busy_d  = '0;
                end
            end
            StGrant: begin
                if (!w_release) begin
                    if (r_busy != '1) begin
                        w_busy_d = r_busy + CNT_W'(1);
                    end
                end else begin
                    w_ptr_d  = r_gnt_idx;
                    w_busy_d = '0;
                    if (|w_others) begin
                        w_gnt_d = w_win_oh;
                        w_idx_d = w_win_idx;
                    end else begin
                        w_state_d = StIdle;
                        w_gnt_d   = '0;
                        w_valid_d = 1'b0;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_ptr       <= 2'b11;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_busy      <= '0;
        end else begin
            r_state     <= w_state_d;
            r_ptr       <= w_ptr_d;
            r_gnt       <= w_gnt_d;
            r_gnt_idx   <= w_idx_d;
            r_gnt_valid <= w_valid_d;
            r_busy      <= w_busy_d;
        end
    end

    assign o_gnt         = r_gnt;
    assign o_gnt_idx     = r_gnt_idx;
    assign o_gnt_valid   = r_gnt_valid;
    assign o_busy_cycles = r_busy;

endmodule

// File: tb/tb_tc_rr_arbiter4.sv
// Scoreboard bench for tc_rr_arbiter4: a behavioural model queues the expected outputs
// for each cycle and a monitor compares them one edge later.
module tb_tc_rr_arbiter4;

    localparam int unsigned MaxHold = 4;
    localparam int unsigned CntW    = 8;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      req   = 4'b0000;
    logic            lock  = 1'b0;
    logic [3:0]      gnt;
    logic [1:0]      gnt_idx;
    logic            gnt_valid;
    logic [CntW-1:0] busy;

    typedef struct packed {
        logic [3:0]      gnt;
        logic [1:0]      idx;
        logic            valid;
        logic [CntW-1:0] busy;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Model state: owner index (-1 when idle), last granted index, pointer, cycles held.
    int m_owner = -1;
    int m_idx   = 0;
    int m_ptr   = 3;
    int m_held  = 0;

    tc_rr_arbiter4 #(
        .MAX_HOLD (MaxHold),
        .CNT_W    (CntW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req),
`ifdef TC_RR_ARBITER4_LOCK_EN
        .i_lock        (lock),
`endif
        .o_gnt         (gnt),
        .o_gnt_idx     (gnt_idx),
        .o_gnt_valid   (gnt_valid),
        .o_busy_cycles (busy)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int p, input bit excl);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4] && !(excl && k == 4)) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_idx   = 0;
        m_ptr   = 3;
        m_held  = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic l);
        logic [3:0] others;
        bit         lk;
        bit         rel;
        int         w;
`ifdef TC_RR_ARBITER4_LOCK_EN
        lk = l;
`else
        lk = 1'b0;
        if (l) lk = 1'b0;
`endif
        if (m_owner < 0) begin
            if (r != 4'b0000) begin
                w       = pick(r, m_ptr, 1'b0);
                m_owner = w;
                m_idx   = w;
                m_held  = 0;
            end
        end else begin
            others = r & ~(4'b0001 << m_owner);
            rel    = !r[m_owner] ||
                     (MaxHold != 0 && m_held == int'(MaxHold) - 1 && others != 0 && !lk);
            if (!rel) begin
                m_held++;
            end else begin
                m_ptr  = m_owner;
                m_held = 0;
                if (others != 0) begin
                    w       = pick(r, m_owner, 1'b1);
                    m_owner = w;
                    m_idx   = w;
                end else begin
                    m_owner = -1;
                end
            end
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.gnt   = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        o.idx   = 2'(m_idx);
        o.valid = (m_owner >= 0);
        o.busy  = (m_held > 255) ? 8'd255 : 8'(m_held);
        return o;
    endfunction

    task automatic drive(input logic [3:0] r, input logic l);
        @(negedge clk);
        req  = r;
        lock = l;
        model_step(r, l);
        exp_q.push_back(model_obs());
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (gnt !== 4'b0000 || gnt_idx !== 2'b00 || gnt_valid !== 1'b0 || busy !== '0) begin
            failures++;
            $display("FAIL %s: got gnt=%b idx=%0d valid=%b busy=%0d, want all zero",
                     name, gnt, gnt_idx, gnt_valid, busy);
        end
    endtask

    // Reset lands mid-cycle so the clear must be asynchronous.
    task automatic async_reset_check();
        @(negedge clk);
        req = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            obs_t e;
            e = exp_q.pop_front();
            checks++;
            if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.valid ||
                busy !== e.busy) begin
                failures++;
                $display("FAIL scoreboard t=%0t: got gnt=%b idx=%0d valid=%b busy=%0d, want gnt=%b idx=%0d valid=%b busy=%0d",
                         $time, gnt, gnt_idx, gnt_valid, busy, e.gnt, e.idx, e.valid, e.busy);
            end
        end
    end

    initial begin
        logic [3:0] r;
        logic       l;
        #1;
        check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, busy counts up.
        repeat (5) drive(4'b0001, 1'b0);
        repeat (2) drive(4'b0000, 1'b0);
        // All requesting: rotation with hold limit and direct switching.
        repeat (20) drive(4'b1111, 1'b0);
        repeat (2) drive(4'b0000, 1'b0);
        // Owner 2 drops with 1011 pending, then 3 drops: wrap to 0.
        repeat (3) drive(4'b0100, 1'b0);
        repeat (2) drive(4'b1011, 1'b0);
        repeat (2) drive(4'b0011, 1'b0);
        repeat (2) drive(4'b0000, 1'b0);
        // No competitor: hold limit never forces release.
        repeat (10) drive(4'b0010, 1'b0);
        repeat (2) drive(4'b0000, 1'b0);
        // Long hold to reach busy saturation.
        repeat (300) drive(4'b1000, 1'b0);
        repeat (2) drive(4'b0000, 1'b0);
        // Reset mid-grant, then restart from pointer 3.
        repeat (3) drive(4'b0100, 1'b0);
        async_reset_check();
        repeat (3) drive(4'b0101, 1'b0);
        repeat (2) drive(4'b0000, 1'b0);
`ifdef TC_RR_ARBITER4_LOCK_EN
        drive(4'b0001, 1'b0);
        repeat (10) drive(4'b0011, 1'b1);
        repeat (3) drive(4'b0011, 1'b0);
        repeat (2) drive(4'b0000, 1'b0);
`endif

        r = 4'b0000;
        l = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) l = ~l;
            if (c == 1500) async_reset_check();
            drive(r, l);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
